// File: rtl/mem2reg_bank.sv
// Register-file bank: single-entry write, bulk increment/clear, a one-entry-per-cycle
// self-initialisation walk, and NRD combinational read ports.
module mem2reg_bank #(
   parameter  int WIDTH = 4,
   parameter  int DEPTH = 8,
   parameter  int NRD   = 2,
   parameter  int SAT   = 0,
   localparam int AW    = (DEPTH <= 2) ? 1 : $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [1:0]           cmd_op,
   input  logic [AW-1:0]        cmd_addr,
   input  logic [WIDTH-1:0]     cmd_data,
   input  logic [NRD*AW-1:0]    rd_addr,
   output logic [NRD*WIDTH-1:0] rd_data,
   output logic                 busy,
   output logic                 done
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_INIT = 1'b1
   } state_t;

   localparam logic [1:0]    OP_WRITE = 2'b00;
   localparam logic [1:0]    OP_INCR  = 2'b01;
   localparam logic [1:0]    OP_INIT  = 2'b10;
   localparam logic [1:0]    OP_CLEAR = 2'b11;
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   state_t               state_r;
   logic [AW-1:0]        cnt_r;
   logic                 busy_r;
   logic                 done_r;
   logic [WIDTH-1:0]     mem_r     [DEPTH];
   logic [WIDTH-1:0]     mem_nxt_s [DEPTH];
   logic                 accept_s;
   logic [NRD*WIDTH-1:0] rd_data_s;

   function automatic logic [WIDTH-1:0] incr_entry(input logic [WIDTH-1:0] v);
      if ((SAT != 0) && (v == {WIDTH{1'b1}})) begin
         return v;
      end else begin
         return v + WIDTH'(1);
      end
   endfunction

   function automatic logic [WIDTH-1:0] index_val(input int i);
      return WIDTH'(i);
   endfunction

   assign cmd_ready = (state_r == ST_IDLE);
   assign accept_s  = cmd_valid & cmd_ready;
   assign busy      = busy_r;
   assign done      = done_r;
   assign rd_data   = rd_data_s;

   // Next contents of the bank: the init walk owns the bank while it runs.
   always_comb begin
      mem_nxt_s = mem_r;
      if (state_r == ST_INIT) begin
         mem_nxt_s[cnt_r] = WIDTH'(cnt_r);
      end else if (accept_s) begin
         case (cmd_op)
            OP_WRITE: begin
               if (int'(cmd_addr) < DEPTH) begin
                  mem_nxt_s[cmd_addr] = cmd_data;
               end else begin
                  mem_nxt_s = mem_r;
               end
            end
            OP_INCR: begin
               for (int i = 0; i < DEPTH; i++) begin
                  mem_nxt_s[i] = incr_entry(mem_r[i]);
               end
            end
            OP_CLEAR: begin
               for (int i = 0; i < DEPTH; i++) begin
                  mem_nxt_s[i] = '0;
               end
            end
            default: begin
               mem_nxt_s = mem_r;
            end
         endcase
      end else begin
         mem_nxt_s = mem_r;
      end
   end

   // Read ports; addresses past the last entry read as zero.
   always_comb begin
      rd_data_s = '0;
      for (int p = 0; p < NRD; p++) begin
         if (int'(rd_addr[p*AW +: AW]) < DEPTH) begin
            rd_data_s[p*WIDTH +: WIDTH] = mem_r[rd_addr[p*AW +: AW]];
         end else begin
            rd_data_s[p*WIDTH +: WIDTH] = '0;
         end
      end
   end

   // Bank storage; reset loads every entry with its own index.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= index_val(i);
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= mem_nxt_s[i];
         end
      end
   end

   // Control FSM with registered busy/done.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
         cnt_r   <= '0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done_r <= 1'b0;
               if (accept_s && (cmd_op == OP_INIT)) begin
                  state_r <= ST_INIT;
                  cnt_r   <= '0;
                  busy_r  <= 1'b1;
               end else begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end
            end
            ST_INIT: begin
               if (cnt_r == LAST_IDX) begin
                  state_r <= ST_IDLE;
                  cnt_r   <= '0;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
               end else begin
                  cnt_r   <= cnt_r + AW'(1);
                  busy_r  <= 1'b1;
                  done_r  <= 1'b0;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               cnt_r   <= '0;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem2reg_bank.sv
// Scoreboard bench for mem2reg_bank: wrapping, saturating and DEPTH=6 instances share
// most stimulus; expected read-backs are queued when stimulus is driven.
module tb_mem2reg_bank;

   localparam logic [1:0] OP_WRITE = 2'b00;
   localparam logic [1:0] OP_INCR  = 2'b01;
   localparam logic [1:0] OP_INIT  = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   logic       clk = 1'b0;
   logic       reset;
   logic       cmd_valid, cmd_valid6;
   logic [1:0] cmd_op;
   logic [2:0] cmd_addr;
   logic [3:0] cmd_data;
   logic [5:0] rd_addr;
   logic [7:0] rd_data_w, rd_data_s, rd_data_6;
   logic       ready_w, ready_s, ready_6;
   logic       busy_w, busy_s, busy_6;
   logic       done_w, done_s, done_6;

   int m_w[8];
   int m_s[8];
   int m_6[6];
   int exp_q[$];
   int obs_q[$];
   int n_cmp = 0;
   int n_bad = 0;

   always #10 clk = ~clk;

   mem2reg_bank #(.WIDTH(4), .DEPTH(8), .NRD(2), .SAT(0)) u_wrap (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(ready_w),
      .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .rd_addr(rd_addr), .rd_data(rd_data_w), .busy(busy_w), .done(done_w));

   mem2reg_bank #(.WIDTH(4), .DEPTH(8), .NRD(2), .SAT(1)) u_sat (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(ready_s),
      .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .rd_addr(rd_addr), .rd_data(rd_data_s), .busy(busy_s), .done(done_s));

   mem2reg_bank #(.WIDTH(4), .DEPTH(6), .NRD(2), .SAT(0)) u_d6 (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid6), .cmd_ready(ready_6),
      .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .rd_addr(rd_addr), .rd_data(rd_data_6), .busy(busy_6), .done(done_6));

   // One command for one edge; the models take the command's final effect.
   task automatic issue(input logic [1:0] op, input logic [2:0] a, input logic [3:0] d,
                        input logic v8, input logic v6);
      cmd_op = op; cmd_addr = a; cmd_data = d; cmd_valid = v8; cmd_valid6 = v6;
      @(posedge clk); #1;
      cmd_valid = 1'b0; cmd_valid6 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (v8) begin
            case (op)
               OP_WRITE: if (i == int'(a)) begin m_w[i] = int'(d); m_s[i] = int'(d); end
               OP_INCR:  begin m_w[i] = (m_w[i] + 1) % 16; m_s[i] = (m_s[i] == 15) ? 15 : m_s[i] + 1; end
               OP_INIT:  begin m_w[i] = i; m_s[i] = i; end
               default:  begin m_w[i] = 0; m_s[i] = 0; end
            endcase
         end
         if (v6 && i < 6) begin
            case (op)
               OP_WRITE: if (i == int'(a)) m_6[i] = int'(d);
               OP_INCR:  m_6[i] = (m_6[i] + 1) % 16;
               OP_INIT:  m_6[i] = i;
               default:  m_6[i] = 0;
            endcase
         end
      end
   endtask

   task automatic push_model();
      for (int a = 0; a < 8; a++) begin
         exp_q.push_back(m_w[a]);
         exp_q.push_back(m_w[7-a]);
         exp_q.push_back(m_s[a]);
         exp_q.push_back((a < 6) ? m_6[a] : 0);
      end
   endtask

   // Read every address through the ports; same lane order as push_model.
   task automatic snapshot();
      for (int a = 0; a < 8; a++) begin
         rd_addr = {3'(7 - a), 3'(a)};
         #1;
         obs_q.push_back(int'(rd_data_w[3:0]));
         obs_q.push_back(int'(rd_data_w[7:4]));
         obs_q.push_back(int'(rd_data_s[3:0]));
         obs_q.push_back(int'(rd_data_6[3:0]));
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; cmd_valid = 1'b0; cmd_valid6 = 1'b0;
      cmd_op = 2'b00; cmd_addr = 3'd0; cmd_data = 4'd0; rd_addr = 6'd0;
      for (int i = 0; i < 8; i++) begin
         m_w[i] = i; m_s[i] = i;
         if (i < 6) m_6[i] = i;
      end
      push_model();
      #25;
      n_cmp++;
      if ({ready_w, ready_s, ready_6} !== 3'b111) begin
         n_bad++; $display("FAIL reset_ready: got %b expected 111", {ready_w, ready_s, ready_6});
      end
      n_cmp++;
      if ({busy_w, busy_s, busy_6, done_w, done_s, done_6} !== 6'b000000) begin
         n_bad++; $display("FAIL reset_busy_done: got %b expected 000000",
                           {busy_w, busy_s, busy_6, done_w, done_s, done_6});
      end
      snapshot();
      for (int k = 0; obs_q.size() > 0; k++) begin
         int e, o;
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o !== e) begin n_bad++; $display("FAIL reset_entries[%0d]: got %0d expected %0d", k, o, e); end
      end
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      rd_addr = {3'd5, 3'd2}; #1;
      n_cmp++;
      if (rd_data_w !== 8'h52) begin n_bad++; $display("FAIL release_read: got %h expected 52", rd_data_w); end
      n_cmp++;
      if ({ready_w, busy_w} !== 2'b10) begin
         n_bad++; $display("FAIL release_ready_busy: got %b expected 10", {ready_w, busy_w});
      end
   endtask

   task automatic test_write_incr();
      issue(OP_WRITE, 3'd3, 4'd9, 1'b1, 1'b1);
      issue(OP_INCR, 3'd0, 4'd0, 1'b1, 1'b1);
      issue(OP_INCR, 3'd0, 4'd0, 1'b1, 1'b1);
      rd_addr = {3'd7, 3'd3}; #1;
      n_cmp++;
      if (rd_data_w !== {4'd9, 4'd11}) begin n_bad++; $display("FAIL e7_e3: got %h expected 9b", rd_data_w); end
      push_model();
      snapshot();
      for (int k = 0; obs_q.size() > 0; k++) begin
         int e, o;
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o !== e) begin n_bad++; $display("FAIL write_incr[%0d]: got %0d expected %0d", k, o, e); end
      end
      issue(OP_WRITE, 3'd0, 4'd15, 1'b1, 1'b1);
      issue(OP_INCR, 3'd0, 4'd0, 1'b1, 1'b1);
      rd_addr = {3'd0, 3'd0}; #1;
      n_cmp++;
      if (rd_data_w[3:0] !== 4'd0) begin n_bad++; $display("FAIL wrap_e0: got %0d expected 0", rd_data_w[3:0]); end
      n_cmp++;
      if (rd_data_s[3:0] !== 4'd15) begin n_bad++; $display("FAIL sat_e0: got %0d expected 15", rd_data_s[3:0]); end
      push_model();
      snapshot();
      for (int k = 0; obs_q.size() > 0; k++) begin
         int e, o;
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o !== e) begin n_bad++; $display("FAIL wrap_sat[%0d]: got %0d expected %0d", k, o, e); end
      end
   endtask

   task automatic test_clear_init();
      int dw = 0;
      int d6 = 0;
      issue(OP_CLEAR, 3'd0, 4'd0, 1'b1, 1'b1);
      issue(OP_INIT, 3'd0, 4'd0, 1'b1, 1'b1);
      for (int c = 0; c < 11; c++) begin
         n_cmp++;
         if ({busy_w, ready_w, done_w, busy_s, ready_s, done_s} !==
             {c < 8, c >= 8, c == 8, c < 8, c >= 8, c == 8}) begin
            n_bad++; $display("FAIL init8_ctrl c=%0d: got %b expected %b", c,
                              {busy_w, ready_w, done_w, busy_s, ready_s, done_s},
                              {c < 8, c >= 8, c == 8, c < 8, c >= 8, c == 8});
         end
         n_cmp++;
         if ({busy_6, ready_6, done_6} !== {c < 6, c >= 6, c == 6}) begin
            n_bad++; $display("FAIL init6_ctrl c=%0d: got %b expected %b", c,
                              {busy_6, ready_6, done_6}, {c < 6, c >= 6, c == 6});
         end
         dw += int'(done_w);
         d6 += int'(done_6);
         if (c == 4) begin
            for (int a = 0; a < 8; a++) begin
               exp_q.push_back((a < 4) ? a : 0);
               exp_q.push_back(((7 - a) < 4) ? (7 - a) : 0);
               exp_q.push_back((a < 4) ? a : 0);
               exp_q.push_back((a < 4) ? a : 0);
            end
            snapshot();
            for (int k = 0; obs_q.size() > 0; k++) begin
               int e, o;
               e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
               if (o !== e) begin n_bad++; $display("FAIL init_partial[%0d]: got %0d expected %0d", k, o, e); end
            end
         end
         @(posedge clk); #1;
      end
      n_cmp++;
      if (dw !== 1) begin n_bad++; $display("FAIL done_count8: got %0d expected 1", dw); end
      n_cmp++;
      if (d6 !== 1) begin n_bad++; $display("FAIL done_count6: got %0d expected 1", d6); end
      push_model();
      snapshot();
      for (int k = 0; obs_q.size() > 0; k++) begin
         int e, o;
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o !== e) begin n_bad++; $display("FAIL init_final[%0d]: got %0d expected %0d", k, o, e); end
      end
   endtask

   task automatic test_back_to_back();
      cmd_op = OP_INIT; cmd_addr = 3'd0; cmd_data = 4'd0; cmd_valid = 1'b1; cmd_valid6 = 1'b1;
      @(posedge clk); #1;
      cmd_op = OP_WRITE; cmd_addr = 3'd0; cmd_data = 4'd6;
      for (int c = 0; c < 10; c++) begin
         if (c == 4) begin
            rd_addr = {3'd1, 3'd0}; #1;
            n_cmp++;
            if ({rd_data_w, rd_data_s, rd_data_6} !== 24'h101010) begin
               n_bad++; $display("FAIL hold_mid: got %h expected 101010", {rd_data_w, rd_data_s, rd_data_6});
            end
         end
         if (c == 8) begin
            rd_addr = {3'd1, 3'd0}; #1;
            n_cmp++;
            if ({rd_data_w[3:0], rd_data_6[3:0]} !== {4'd0, 4'd6}) begin
               n_bad++; $display("FAIL hold_landing: got %h expected 06", {rd_data_w[3:0], rd_data_6[3:0]});
            end
         end
         if (c == 9) begin
            cmd_valid = 1'b0; cmd_valid6 = 1'b0;
         end
         @(posedge clk); #1;
      end
      for (int i = 0; i < 8; i++) begin
         m_w[i] = i; m_s[i] = i;
         if (i < 6) m_6[i] = i;
      end
      m_w[0] = 6; m_s[0] = 6; m_6[0] = 6;
      push_model();
      snapshot();
      for (int k = 0; obs_q.size() > 0; k++) begin
         int e, o;
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o !== e) begin n_bad++; $display("FAIL hold_final[%0d]: got %0d expected %0d", k, o, e); end
      end
   endtask

   task automatic test_reset_mid_init();
      int nd = 0;
      issue(OP_CLEAR, 3'd0, 4'd0, 1'b1, 1'b1);
      issue(OP_INIT, 3'd0, 4'd0, 1'b1, 1'b1);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
      end
      reset = 1'b0; #1;
      n_cmp++;
      if ({busy_w, busy_s, busy_6, done_w, done_s, done_6, ready_w, ready_s, ready_6} !== 9'b000000111) begin
         n_bad++; $display("FAIL abort_ctrl: got %b expected 000000111",
                           {busy_w, busy_s, busy_6, done_w, done_s, done_6, ready_w, ready_s, ready_6});
      end
      for (int i = 0; i < 8; i++) begin
         m_w[i] = i; m_s[i] = i;
         if (i < 6) m_6[i] = i;
      end
      push_model();
      snapshot();
      for (int k = 0; obs_q.size() > 0; k++) begin
         int e, o;
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o !== e) begin n_bad++; $display("FAIL abort_entries[%0d]: got %0d expected %0d", k, o, e); end
      end
      @(negedge clk); reset = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         nd += int'(done_w) + int'(done_s) + int'(done_6) + int'(busy_w) + int'(busy_s) + int'(busy_6);
      end
      n_cmp++;
      if (nd !== 0) begin n_bad++; $display("FAIL abort_no_done: got %0d busy/done samples expected 0", nd); end
      n_cmp++;
      if ({ready_w, ready_s, ready_6} !== 3'b111) begin
         n_bad++; $display("FAIL abort_ready: got %b expected 111", {ready_w, ready_s, ready_6});
      end
   endtask

   task automatic test_d6_oob();
      issue(OP_WRITE, 3'd7, 4'd4, 1'b0, 1'b1);
      issue(OP_WRITE, 3'd6, 4'd4, 1'b0, 1'b1);
      push_model();
      snapshot();
      for (int k = 0; obs_q.size() > 0; k++) begin
         int e, o;
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
         if (o !== e) begin n_bad++; $display("FAIL d6_oob[%0d]: got %0d expected %0d", k, o, e); end
      end
      rd_addr = {3'd7, 3'd6}; #1;
      n_cmp++;
      if (rd_data_6 !== 8'h00) begin n_bad++; $display("FAIL d6_oob_read: got %h expected 00", rd_data_6); end
   endtask

   initial begin
      test_reset();
      test_write_incr();
      test_clear_init();
      test_back_to_back();
      test_reset_mid_init();
      test_d6_oob();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem2reg_bank.md
MEM2REG_BANK -- requirements
Module: mem2reg_bank

Interface
REQ-001 Parameter WIDTH, default 4: bits per entry, 1..32.
REQ-002 Parameter DEPTH, default 8: number of entries, 2..256; need not be a power of two.
REQ-003 Parameter NRD, default 2: number of combinational read ports, 1..4.
REQ-004 Parameter SAT, default 0: increment mode; 0 = wrap, 1 = saturate at all-ones.
REQ-005 Derived AW = max(1, clog2(DEPTH)): address width.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 reset  input  1  asynchronous, active-low reset; asserted while 0.
REQ-008 cmd_valid  input  1  command request.
REQ-009 cmd_ready  output  1  block can accept a command this cycle.
REQ-010 cmd_op  input  2  00 WRITE, 01 INCR_ALL, 10 INIT_SEQ, 11 CLEAR_ALL.
REQ-011 cmd_addr  input  AW  target entry for WRITE.
REQ-012 cmd_data  input  WIDTH  write data for WRITE.
REQ-013 rd_addr  input  NRD*AW  packed read addresses; port p uses bits [p*AW +: AW].
REQ-014 rd_data  output  NRD*WIDTH  packed read data; port p uses bits [p*WIDTH +: WIDTH].
REQ-015 busy  output  1  INIT_SEQ in progress.
REQ-016 done  output  1  one-cycle pulse when INIT_SEQ completes.

Function
REQ-017 A command is accepted on a rising clk edge where cmd_valid and cmd_ready are both 1.
REQ-018 cmd_ready = 1 in state IDLE and 0 in state INIT; it is a combinational function of state only.
REQ-019 FSM states: IDLE, INIT. IDLE->INIT on acceptance of INIT_SEQ. INIT->IDLE on the cycle that writes entry DEPTH-1. All other conditions keep the current state.
REQ-020 WRITE: on the accepting edge, entry cmd_addr <= cmd_data. cmd_addr >= DEPTH is accepted and has no effect.
REQ-021 INCR_ALL: on the accepting edge, every entry <= entry+1 (modulo 2^WIDTH when SAT=0; held at 2^WIDTH-1 when SAT=1). Single-cycle.
REQ-022 CLEAR_ALL: on the accepting edge, every entry <= 0. Single-cycle.
REQ-023 INIT_SEQ: starting on the edge after acceptance, one entry is written per cycle in ascending order, entry k <= k mod 2^WIDTH. The sequence occupies DEPTH cycles; busy = 1 throughout and cmd_ready = 0.
REQ-024 done = 1 for exactly the one cycle after entry DEPTH-1 is written; cmd_ready returns to 1 in that same cycle.
REQ-025 rd_data port p is combinational from the current register contents: entry rd_addr[p] if rd_addr[p] < DEPTH, else 0.
REQ-026 A read of an entry being written in the same cycle returns the old value; the new value is visible after the edge.
REQ-027 During INIT, reads return the partially initialised contents: entries already written hold their index, the rest hold their prior values.
REQ-028 cmd_valid while cmd_ready = 0 is ignored; the command is neither stored nor queued.
REQ-029 Only one command executes per edge; ops never merge.
REQ-030 cmd_op, cmd_addr and cmd_data are don't-care when cmd_valid = 0.

Reset
REQ-031 reset = 0 asynchronously forces: entry i = i mod 2^WIDTH for every i; state = IDLE; internal init counter = 0; busy = 0; done = 0.
REQ-032 cmd_ready = 1 while reset = 0 (state is IDLE).
REQ-033 Reset asserted mid-INIT aborts the sequence immediately; entries take their reset values, and no done pulse is produced.
REQ-034 Reset deassertion is assumed synchronous to clk by the integrator; the first command may be accepted on the first edge after deassertion.

Verification (WIDTH=4, DEPTH=8, NRD=2 unless stated)
REQ-035 Release reset, rd_addr = {3'd5, 3'd2} -> rd_data = {4'd5, 4'd2}; cmd_ready = 1, busy = 0.
REQ-036 Issue WRITE addr 3 data 9, then INCR_ALL twice -> entry3 = 11 and entry7 = 9; with SAT=0, a WRITE of 15 to entry0 followed by INCR_ALL gives entry0 = 0; with SAT=1 it gives 15.
REQ-037 Issue CLEAR_ALL, then INIT_SEQ -> cmd_ready = 0 and busy = 1 for 8 cycles; at cycle 4 after acceptance entries0..3 = index and entries4..7 = 0; done pulses once; all entries then equal their index.
REQ-038 Keep cmd_valid = 1 with WRITE addr 0 data 6 asserted throughout INIT -> no effect until cmd_ready = 1; the write lands on the first ready edge.
REQ-039 Assert reset at cycle 3 of INIT -> busy = 0, entries = index, no done pulse; cmd_ready = 1 after release.
REQ-040 DEPTH=6: WRITE addr 7 data 4 leaves all entries unchanged; rd_addr 6 or 7 returns 0; INIT_SEQ takes 6 cycles.
